mult_sequencer: RTL and testbench

Control unit for the sequential signed shift-and-add multiplier. It accepts a debounced start pulse and sequences the magnitude datapath: one load cycle, then test/add/shift iterations until the multiplier register empties or WIDTH shifts complete. It captures the product sign and tracks the three-digit display window that the left/right buttons scroll. It sits between the push-button detectors and the multiplier datapath, BCD converter and display mux, all on the divided clock.

---
 rtl/mult_sequencer.sv | 137 +++++++++++++
 tb/tb_mult_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// mult_sequencer
// ----------------------------------------------------------------------------
// Control unit for the sequential signed shift-and-add multiplier. A start
// pulse loads the magnitude datapath, then the FSM walks test/add/shift
// iterations until the multiplier register empties or WIDTH shifts are done.
// It also captures the product sign and owns the three-digit display window.
//
// Parameters
//   WIDTH    operand magnitude width and maximum number of shift iterations
//   WIN_MAX  highest display window index (window saturates here)
//
// Ports
//   clk           divided system clock, rising-edge active
//   rst           asynchronous reset, active low
//   start         one-cycle start pulse (ignored while busy)
//   scroll_left   one-cycle pulse, window toward more significant digits
//   scroll_right  one-cycle pulse, window toward less significant digits
//   sign_mp       multiplier sign bit
//   sign_mc       multiplicand sign bit
//   op_zero       either operand magnitude is zero
//   zero_flag     datapath multiplier register is zero
//   lsb           datapath multiplier register LSB
//   load_initial  datapath load strobe
//   add_en        accumulate strobe
//   shift_en      shift strobe
//   busy          multiplication in progress
//   done          result valid, held until the next accepted start
//   neg_flag      product sign
//   window        display window index, 0..WIN_MAX
//   iter_cnt      shifts completed in the current operation
// ----------------------------------------------------------------------------
module mult_sequencer #(
    parameter int WIDTH   = 8,
    parameter int WIN_MAX = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       scroll_left,
    input  logic       scroll_right,
    input  logic       sign_mp,
    input  logic       sign_mc,
    input  logic       op_zero,
    input  logic       zero_flag,
    input  logic       lsb,
    output logic       load_initial,
    output logic       add_en,
    output logic       shift_en,
    output logic       busy,
    output logic       done,
    output logic       neg_flag,
    output logic [1:0] window,
    output logic [3:0] iter_cnt
);

    localparam logic [3:0] ITER_MAX = 4'(WIDTH);
    localparam logic [1:0] WIN_TOP  = 2'(WIN_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TEST,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] iter_q,  iter_d;
    logic [1:0] win_q,   win_d;
    logic       neg_q,   neg_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            win_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            win_q   <= win_d;
            neg_q   <= neg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        win_d   = win_q;
        neg_d   = neg_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Accepting start clears the per-operation state; any
                    // scroll pulse in the same cycle is dropped.
                    state_d = S_LOAD;
                    iter_d  = '0;
                    win_d   = '0;
                    // A zero product must never show as negative.
                    neg_d   = (sign_mp ^ sign_mc) & ~op_zero;
                end else if (scroll_left && !scroll_right) begin
                    if (win_q != WIN_TOP) win_d = win_q + 2'd1;
                end else if (scroll_right && !scroll_left) begin
                    if (win_q != 2'd0) win_d = win_q - 2'd1;
                end
            end
            S_LOAD: state_d = S_TEST;
            S_TEST: begin
                if (zero_flag)              state_d = S_DONE;
                else if (iter_q == ITER_MAX) state_d = S_DONE;
                else if (lsb)               state_d = S_ADD;
                else                        state_d = S_SHIFT;
            end
            S_ADD:  state_d = S_SHIFT;
            S_SHIFT: begin
                iter_d  = iter_q + 4'd1;
                state_d = S_TEST;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs: strobes are decoded from the state register only, so
    // they are mutually exclusive and drop immediately with reset.
    assign load_initial = (state_q == S_LOAD);
    assign add_en       = (state_q == S_ADD);
    assign shift_en     = (state_q == S_SHIFT);
    assign busy         = (state_q == S_LOAD) || (state_q == S_TEST) ||
                          (state_q == S_ADD)  || (state_q == S_SHIFT);
    assign done         = (state_q == S_DONE);
    assign neg_flag     = neg_q;
    assign window       = win_q;
    assign iter_cnt     = iter_q;

endmodule

// File: tb/tb_mult_sequencer.sv
module tb_mult_sequencer;
    localparam int WIDTH   = 8;
    localparam int WIN_MAX = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, scroll_left = 1'b0, scroll_right = 1'b0;
    logic sign_mp = 1'b0, sign_mc = 1'b0;
    logic op_zero, zero_flag, lsb;
    logic load_initial, add_en, shift_en, busy, done, neg_flag;
    logic [1:0] window;
    logic [3:0] iter_cnt;

    int total = 0;
    int bad   = 0;

    // Behavioural datapath: a multiplier register that loads and shifts.
    logic [7:0] cur_mag = 8'd0, cur_mc = 8'd0, dp_mp = 8'd0;
    logic       force_nz = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_initial)  dp_mp <= cur_mag;
        else if (shift_en) dp_mp <= dp_mp >> 1;
    end

    assign op_zero   = (cur_mag == 8'd0) || (cur_mc == 8'd0);
    assign zero_flag = force_nz ? 1'b0 : (dp_mp == 8'd0);
    assign lsb       = dp_mp[0];

    mult_sequencer #(.WIDTH(WIDTH), .WIN_MAX(WIN_MAX)) dut (
        .clk(clk), .rst(rst), .start(start),
        .scroll_left(scroll_left), .scroll_right(scroll_right),
        .sign_mp(sign_mp), .sign_mc(sign_mc), .op_zero(op_zero),
        .zero_flag(zero_flag), .lsb(lsb),
        .load_initial(load_initial), .add_en(add_en), .shift_en(shift_en),
        .busy(busy), .done(done), .neg_flag(neg_flag),
        .window(window), .iter_cnt(iter_cnt)
    );

    // One full operation; expectations come from walking the multiplier bits.
    task automatic run_op(input logic [7:0] mag, input logic [7:0] mc,
                          input logic smp, input logic smc, input logic nz,
                          input logic bstart, input logic bscroll, input string name);
        string      trace, exp_trace;
        int         n, exp_done, it;
        logic [7:0] m;
        logic       exp_neg;
        exp_trace = "L"; exp_done = 3; it = 0; m = mag;
        while ((nz || m != 8'd0) && it < WIDTH) begin
            if (m[0]) begin exp_trace = {exp_trace, "AS"}; exp_done += 3; end
            else      begin exp_trace = {exp_trace, "S"};  exp_done += 2; end
            m = m >> 1; it++;
        end
        exp_neg = (smp ^ smc) && mag != 0 && mc != 0;

        @(negedge clk);
        cur_mag = mag; cur_mc = mc; sign_mp = smp; sign_mc = smc; force_nz = nz;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1; trace = "";
        while (n < 100) begin
            if (load_initial) trace = {trace, "L"};
            if (add_en)       trace = {trace, "A"};
            if (shift_en)     trace = {trace, "S"};
            if (n == 2) begin
                total++;
                if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_mid got=%b want=1", name, busy); end
            end
            if (done) break;
            start       = bstart  && (n == 4);
            scroll_left = bscroll && (n == 3);
            @(negedge clk);
            n++;
        end
        start = 1'b0; scroll_left = 1'b0;
        total++;
        if (n !== exp_done) begin bad++; $display("FAIL %s done_edge got=%0d want=%0d", name, n, exp_done); end
        total++;
        if (trace != exp_trace) begin bad++; $display("FAIL %s strobes got=%s want=%s", name, trace, exp_trace); end
        total++;
        if (iter_cnt !== 4'(it)) begin bad++; $display("FAIL %s iter_cnt got=%0d want=%0d", name, iter_cnt, it); end
        total++;
        if (neg_flag !== exp_neg) begin bad++; $display("FAIL %s neg_flag got=%b want=%b", name, neg_flag, exp_neg); end
        total++;
        if (busy !== 1'b0 || window !== 2'd0) begin
            bad++; $display("FAIL %s idle_outputs busy=%b window=%0d want busy=0 window=0", name, busy, window);
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({load_initial, add_en, shift_en, busy, done, neg_flag, window, iter_cnt} !== 12'd0) begin
            bad++; $display("FAIL reset outputs got=%b want=0", {load_initial, add_en, shift_en, busy, done, neg_flag, window, iter_cnt});
        end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_reset_mid();
        int k;
        @(negedge clk);
        cur_mag = 8'd5; cur_mc = 8'd3; sign_mp = 1'b1; sign_mc = 1'b0; force_nz = 1'b0;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (!shift_en && k < 20) begin @(negedge clk); k++; end
        total++;
        if (!shift_en) begin bad++; $display("FAIL reset_mid no_shift got=0 want=1"); end
        rst = 1'b0;
        #1;
        total++;
        if ({load_initial, add_en, shift_en, busy, done, neg_flag, window, iter_cnt} !== 12'd0) begin
            bad++; $display("FAIL reset_mid outputs got=%b want=0", {load_initial, add_en, shift_en, busy, done, neg_flag, window, iter_cnt});
        end
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || shift_en !== 1'b0) begin
            bad++; $display("FAIL reset_mid after_release done=%b busy=%b shift=%b want 0", done, busy, shift_en);
        end
    endtask

    task automatic test_basic();
        run_op(8'd5,   8'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "mag5_busy_start");
        run_op(8'd0,   8'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "mag0");
        run_op(8'hFF,  8'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "magFF_max");
        run_op(8'd12,  8'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "sign_both");
        run_op(8'd12,  8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "mc_zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, "random");
        end
    endtask

    task automatic test_window();
        int exp_w, k;
        logic l, r;
        exp_w = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); scroll_left = 1'b1;
            @(negedge clk); scroll_left = 1'b0;
            exp_w = (exp_w < WIN_MAX) ? exp_w + 1 : WIN_MAX;
            total++;
            if (window !== 2'(exp_w)) begin bad++; $display("FAIL window_left got=%0d want=%0d", window, exp_w); end
        end
        @(negedge clk); scroll_left = 1'b1; scroll_right = 1'b1;
        @(negedge clk); scroll_left = 1'b0; scroll_right = 1'b0;
        total++;
        if (window !== 2'(exp_w)) begin bad++; $display("FAIL window_both got=%0d want=%0d", window, exp_w); end
        for (int i = 0; i < 16; i++) begin
            l = 1'($urandom); r = 1'($urandom);
            @(negedge clk); scroll_left = l; scroll_right = r;
            @(negedge clk); scroll_left = 1'b0; scroll_right = 1'b0;
            if (l && !r) exp_w = (exp_w < WIN_MAX) ? exp_w + 1 : WIN_MAX;
            if (r && !l) exp_w = (exp_w > 0) ? exp_w - 1 : 0;
            total++;
            if (window !== 2'(exp_w)) begin bad++; $display("FAIL window_rand got=%0d want=%0d", window, exp_w); end
        end
        // Make sure the window is off zero so the clear on start is visible.
        @(negedge clk); scroll_left = 1'b1;
        @(negedge clk); scroll_left = 1'b0;
        cur_mag = 8'd3; cur_mc = 8'd3; force_nz = 1'b0;
        start = 1'b1; scroll_right = 1'b1;
        @(negedge clk); start = 1'b0; scroll_right = 1'b0;
        total++;
        if (load_initial !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL start_scroll load got=%b busy=%b want 1", load_initial, busy);
        end
        k = 0;
        while (!done && k < 60) begin @(negedge clk); k++; end
        total++;
        if (done !== 1'b1 || window !== 2'd0) begin
            bad++; $display("FAIL start_scroll window done=%b window=%0d want done=1 window=0", done, window);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_basic();
        test_random();
        test_window();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
